// File: rtl/uart_tx_fifo_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_fifo_top: baud generator + TX FIFO + framing FSM, LSB-first out.  |
// | Optional parity bit when UART_TX_PARITY_EN is defined.   Rev 1.0          |
// +--------------------------------------------------------------------------+
module uart_tx_fifo_top #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_int,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              tx_ovf,
  output logic              tx_busy,
  output logic              rs232_tx,
  output logic              tx_end
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] C_TICK_AT   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] C_END_AT    = CNT_W'(DIV - 2);
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic             C_LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   C_FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_ovf;
  logic              w_push, w_pop, w_full, w_empty;
  logic [DATA_W-1:0] w_head;

  state_t            r_state, w_state_n;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_tick;
  logic [DATA_W-1:0] r_shift, w_shift_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic              r_stop_idx, w_stop_idx_n;
  logic              r_line, w_line_n;
  logic              r_end, w_end_n;

  // ---------------------------------------------------------------- FIFO
  assign w_full  = (r_count == C_FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = tx_int && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // a write into a full FIFO is dropped even if a pop frees a slot this cycle
      r_ovf <= tx_int && w_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- parity
`ifdef UART_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_par <= 1'b0;
    else if (w_pop) r_par <= (^w_head) ^ (PARITY_ODD != 0);
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (PARITY_ODD != 0);
`endif

  // ---------------------------------------------------------------- framing FSM
  assign w_tick = (r_state != S_IDLE) && (r_cnt == C_TICK_AT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_line     <= 1'b1;
      r_end      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_shift    <= w_shift_n;
      r_idx      <= w_idx_n;
      r_stop_idx <= w_stop_idx_n;
      r_line     <= w_line_n;
      r_end      <= w_end_n;
      // every pop enters START, so the start bit always gets a full DIV cycles
      if (w_state_n == S_IDLE || w_tick || w_pop) r_cnt <= '0;
      else                                        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_pop        = 1'b0;
    w_shift_n    = r_shift;
    w_idx_n      = r_idx;
    w_stop_idx_n = r_stop_idx;
    w_end_n      = 1'b0;
    w_line_n     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_n = S_DATA;
          w_idx_n   = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_n = r_shift >> 1;
          w_idx_n   = r_idx + 1'b1;
          if (r_idx == C_LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n    = S_STOP;
            w_stop_idx_n = 1'b0;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_state_n    = S_STOP;
          w_stop_idx_n = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_stop_idx == C_LAST_STOP) begin
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_shift_n = w_head;
              w_state_n = S_START;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_stop_idx_n = 1'b1;
          end
        end else if (r_stop_idx == C_LAST_STOP && r_cnt == C_END_AT) begin
          // registered one cycle early so the pulse covers the final stop cycle
          w_end_n = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    case (w_state_n)
      S_START:  w_line_n = 1'b0;
      S_DATA:   w_line_n = w_shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_line_n = r_par;
`endif
      default:  w_line_n = 1'b1;
    endcase
  end

  assign tx_full  = w_full;
  assign tx_empty = w_empty;
  assign tx_ovf   = r_ovf;
  assign tx_busy  = (r_state != S_IDLE);
  assign rs232_tx = r_line;
  assign tx_end   = r_end;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_fifo_top: random words against a frame-level reference model. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_uart_tx_fifo_top;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif
  localparam int DEPTH  = 4;
  localparam int FRAME0 = (1 + 8 + PBIT + 1) * DIV;
  localparam int FRAME1 = (1 + 7 + PBIT + 2) * DIV;
  localparam int MAXC   = 800;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] tx_data0 = '0;
  logic       tx_int0 = 1'b0;
  logic       tx_full0, tx_empty0, tx_ovf0, tx_busy0, rs232_tx0, tx_end0;
  logic [6:0] tx_data1 = '0;
  logic       tx_int1 = 1'b0;
  logic       tx_full1, tx_empty1, tx_ovf1, tx_busy1, rs232_tx1, tx_end1;

  always #5 clk = ~clk;

  uart_tx_fifo_top #(.CLK_HZ(1000), .BAUD(100), .DATA_W(8), .FIFO_DEPTH(DEPTH),
                     .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_int(tx_int0),
    .tx_full(tx_full0), .tx_empty(tx_empty0), .tx_ovf(tx_ovf0),
    .tx_busy(tx_busy0), .rs232_tx(rs232_tx0), .tx_end(tx_end0));

  uart_tx_fifo_top #(.CLK_HZ(1000), .BAUD(100), .DATA_W(7), .FIFO_DEPTH(DEPTH),
                     .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_int(tx_int1),
    .tx_full(tx_full1), .tx_empty(tx_empty1), .tx_ovf(tx_ovf1),
    .tx_busy(tx_busy1), .rs232_tx(rs232_tx1), .tx_end(tx_end1));

  int total = 0;
  int bad   = 0;

  logic [8:0] wr_words [8];
  // bit order {full, empty, ovf, busy, end, line}
  logic [5:0] cap  [MAXC];
  logic [5:0] expv [MAXC];
  int         exp_frames;

  function automatic string sig_name(input int k);
    case (k)
      0: return "rs232_tx";
      1: return "tx_end";
      2: return "tx_busy";
      3: return "tx_ovf";
      4: return "tx_empty";
      default: return "tx_full";
    endcase
  endfunction

  // Bit b of a frame: start, data LSB first, optional parity, then stop bits.
  function automatic logic frame_bit(input logic [8:0] w, input int b, input int dw, input int podd);
    int ones;
    ones = 0;
    if (b == 0) return 1'b0;
    if (b <= dw) return w[b-1];
    if (PBIT == 1 && b == dw + 1) begin
      for (int i = 0; i < dw; i++) ones += int'(w[i]);
      return ((ones % 2) ^ podd) != 0;
    end
    return 1'b1;
  endfunction

  function automatic int first_diff(input int k, input int n);
    for (int i = 0; i < n; i++)
      if (cap[i][k] !== expv[i][k]) return i;
    return -1;
  endfunction

  function automatic int count_bit(input int k, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (cap[i][k] === 1'b1) c++;
    return c;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [8:0] w);
    if (sel == 0) begin tx_int0 = v; tx_data0 = w[7:0]; end
    else          begin tx_int1 = v; tx_data1 = w[6:0]; end
  endtask

  // Word k is sampled at edge E_k; cap[i] holds outputs after edge E_i.
  task automatic run_words(input int sel, input int nw, input int ncyc);
    @(negedge clk);
    drive(sel, 1'b1, wr_words[0]);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (sel == 0) cap[i] = {tx_full0, tx_empty0, tx_ovf0, tx_busy0, tx_end0, rs232_tx0};
      else          cap[i] = {tx_full1, tx_empty1, tx_ovf1, tx_busy1, tx_end1, rs232_tx1};
      if (i + 1 < nw) drive(sel, 1'b1, wr_words[i+1]);
      else            drive(sel, 1'b0, 9'd0);
    end
  endtask

  // Frame-level model: acceptance from FIFO occupancy, frame start times from
  // word availability and the end of the previous frame.
  task automatic build_model(input int sel, input int nw, input int ncyc);
    int dw, podd, frame, prev_end, occ, p, cnt;
    int acc_t[$];
    int pop_t[$];
    int drop_t[$];
    logic [8:0] acc_w[$];
    logic l, e, b, o;
    dw = (sel == 0) ? 8 : 7;
    podd = sel;
    frame = (sel == 0) ? FRAME0 : FRAME1;
    prev_end = 0;
    for (int k = 0; k < nw; k++) begin
      occ = acc_t.size();
      foreach (pop_t[j]) if (pop_t[j] < k) occ--;
      if (occ < DEPTH) begin
        p = (k + 1 > prev_end) ? k + 1 : prev_end;
        acc_t.push_back(k);
        acc_w.push_back(wr_words[k]);
        pop_t.push_back(p);
        prev_end = p + frame;
      end else begin
        drop_t.push_back(k);
      end
    end
    exp_frames = acc_t.size();
    for (int i = 0; i < ncyc; i++) begin
      l = 1'b1; e = 1'b0; b = 1'b0; o = 1'b0; cnt = 0;
      foreach (acc_t[j]) begin
        if (i >= pop_t[j] && i < pop_t[j] + frame) begin
          l = frame_bit(acc_w[j], (i - pop_t[j]) / DIV, dw, podd);
          b = 1'b1;
        end
        if (i == pop_t[j] + frame - 1) e = 1'b1;
        if (acc_t[j] <= i) cnt++;
        if (pop_t[j] <= i) cnt--;
      end
      foreach (drop_t[j]) if (drop_t[j] == i) o = 1'b1;
      expv[i] = {cnt == DEPTH, cnt == 0, o, b, e, l};
    end
  endtask

  task automatic test_reset();
    logic [5:0] s0, s1;
    repeat (3) @(negedge clk);
    s0 = {tx_full0, tx_empty0, tx_ovf0, tx_busy0, tx_end0, rs232_tx0};
    s1 = {tx_full1, tx_empty1, tx_ovf1, tx_busy1, tx_end1, rs232_tx1};
    total++;
    if (s0 !== 6'b010001) begin
      bad++; $display("FAIL reset_dut0 got %b want %b", s0, 6'b010001);
    end
    total++;
    if (s1 !== 6'b010001) begin
      bad++; $display("FAIL reset_dut1 got %b want %b", s1, 6'b010001);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    int n, d, pos;
    n = FRAME0 + 15;
    wr_words[0] = 9'h0A5;
    run_words(0, 1, n);
    build_model(0, 1, n);
    for (int k = 0; k < 6; k++) begin
      d = first_diff(k, n);
      total++;
      if (d !== -1) begin
        bad++; $display("FAIL single_%s cycle %0d got %b want %b", sig_name(k), d, cap[d][k], expv[d][k]);
      end
    end
    pos = -1;
    for (int i = 0; i < n; i++) if (cap[i][1] === 1'b1 && pos < 0) pos = i;
    total++;
    if (pos !== FRAME0) begin
      bad++; $display("FAIL single_end_position got %0d want %0d", pos, FRAME0);
    end
  endtask

  task automatic test_parity_words();
    int n, d, ends;
    n = 2 * FRAME0 + 15;
    wr_words[0] = 9'h0A5;
    wr_words[1] = 9'h007;
    run_words(0, 2, n);
    build_model(0, 2, n);
    for (int k = 0; k < 6; k++) begin
      d = first_diff(k, n);
      total++;
      if (d !== -1) begin
        bad++; $display("FAIL parity_%s cycle %0d got %b want %b", sig_name(k), d, cap[d][k], expv[d][k]);
      end
    end
    ends = count_bit(1, n);
    total++;
    if (ends !== 2) begin
      bad++; $display("FAIL parity_end_count got %0d want 2", ends);
    end
  endtask

  task automatic test_back_to_back();
    int n, d, last, gaps_bad;
    n = 3 * FRAME0 + 15;
    for (int k = 0; k < 3; k++) wr_words[k] = 9'($urandom_range(0, 255));
    run_words(0, 3, n);
    build_model(0, 3, n);
    for (int k = 0; k < 6; k++) begin
      d = first_diff(k, n);
      total++;
      if (d !== -1) begin
        bad++; $display("FAIL b2b_%s cycle %0d got %b want %b", sig_name(k), d, cap[d][k], expv[d][k]);
      end
    end
    last = 0;
    gaps_bad = 0;
    for (int i = 0; i < n; i++)
      if (cap[i][1] === 1'b1) begin
        if (i - last != FRAME0) gaps_bad++;
        last = i;
      end
    total++;
    if (gaps_bad !== 0 || last !== 3 * FRAME0) begin
      bad++; $display("FAIL b2b_end_spacing got bad_gaps=%0d last=%0d want 0 and %0d", gaps_bad, last, 3 * FRAME0);
    end
  endtask

  task automatic test_overflow();
    int n, d, ovfs, ends;
    n = 5 * FRAME0 + 15;
    for (int k = 0; k < 6; k++) wr_words[k] = 9'($urandom_range(0, 255));
    run_words(0, 6, n);
    build_model(0, 6, n);
    for (int k = 0; k < 6; k++) begin
      d = first_diff(k, n);
      total++;
      if (d !== -1) begin
        bad++; $display("FAIL ovf_%s cycle %0d got %b want %b", sig_name(k), d, cap[d][k], expv[d][k]);
      end
    end
    ovfs = count_bit(3, n);
    ends = count_bit(1, n);
    total++;
    if (ovfs !== 1 || ends !== 5 || exp_frames !== 5) begin
      bad++; $display("FAIL ovf_counts got ovf=%0d frames=%0d model=%0d want 1 5 5", ovfs, ends, exp_frames);
    end
    total++;
    if (cap[4][5] !== 1'b1) begin
      bad++; $display("FAIL ovf_full_after_word5 got %b want 1", cap[4][5]);
    end
  endtask

  task automatic test_seven_two();
    int n, d, highs;
    n = 2 * FRAME1 + 15;
    wr_words[0] = 9'h055;
    wr_words[1] = 9'($urandom_range(0, 127));
    run_words(1, 2, n);
    build_model(1, 2, n);
    for (int k = 0; k < 6; k++) begin
      d = first_diff(k, n);
      total++;
      if (d !== -1) begin
        bad++; $display("FAIL d7s2_%s cycle %0d got %b want %b", sig_name(k), d, cap[d][k], expv[d][k]);
      end
    end
    highs = 0;
    for (int i = FRAME1 - 19; i <= FRAME1; i++) if (cap[i][0] === 1'b1) highs++;
    total++;
    if (highs !== 20) begin
      bad++; $display("FAIL d7s2_stop_high_cycles got %0d want 20", highs);
    end
  endtask

  task automatic test_reset_mid();
    int n, d, ends, lows;
    logic [2:0] s;
    wr_words[0] = 9'($urandom_range(0, 255));
    wr_words[1] = 9'($urandom_range(0, 255));
    @(negedge clk); drive(0, 1'b1, wr_words[0]);
    @(negedge clk); drive(0, 1'b1, wr_words[1]);
    @(negedge clk); drive(0, 1'b0, 9'd0);
    repeat (44) @(negedge clk);
    total++;
    if (tx_busy0 !== 1'b1 || rs232_tx0 !== wr_words[0][3]) begin
      bad++; $display("FAIL midreset_before got busy=%b line=%b want 1 %b", tx_busy0, rs232_tx0, wr_words[0][3]);
    end
    #2 rst = 1'b1;
    #1 s = {rs232_tx0, tx_busy0, tx_empty0};
    total++;
    if (s !== 3'b101) begin
      bad++; $display("FAIL midreset_immediate got line,busy,empty=%b want 101", s);
    end
    @(negedge clk);
    rst = 1'b0;
    ends = 0;
    lows = 0;
    for (int i = 0; i < 2 * FRAME0; i++) begin
      @(negedge clk);
      if (tx_end0 === 1'b1) ends++;
      if (rs232_tx0 !== 1'b1) lows++;
    end
    total++;
    if (ends !== 0 || lows !== 0) begin
      bad++; $display("FAIL midreset_quiet got ends=%0d low_cycles=%0d want 0 0", ends, lows);
    end
    n = FRAME0 + 15;
    wr_words[0] = 9'($urandom_range(0, 255));
    run_words(0, 1, n);
    build_model(0, 1, n);
    for (int k = 0; k < 6; k++) begin
      d = first_diff(k, n);
      total++;
      if (d !== -1) begin
        bad++; $display("FAIL midreset_after_%s cycle %0d got %b want %b", sig_name(k), d, cap[d][k], expv[d][k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_parity_words();
    test_back_to_back();
    test_overflow();
    test_seven_two();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_top.md
# uart_tx_fifo_top

Parametrised UART transmit subsystem: a baud-rate generator, a transmit FIFO and a framing state machine in one block. The host writes words into the FIFO and the block serialises them LSB-first onto `rs232_tx`. It adds configurable data width, stop bits, optional parity, buffering and back-to-back frames. It sits between the on-chip data source (RAM readout logic) and the board RS232 pin.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate. The divisor is `DIV = CLK_HZ / BAUD`, truncated. It must be ≥ 2.
- `DATA_W`, 8: data bits per frame, from 5 to 9.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Used only with `UART_TX_PARITY_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: system clock. All logic updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `tx_data`, in, `DATA_W`: word to enqueue.
- `tx_int`, in, 1: write strobe, one word per high cycle.
- `tx_full`, out, 1: FIFO holds `FIFO_DEPTH` words.
- `tx_empty`, out, 1: FIFO holds 0 words.
- `tx_ovf`, out, 1: one-cycle pulse when a write is dropped.
- `tx_busy`, out, 1: high whenever the FSM is not in IDLE.
- `rs232_tx`, out, 1: serial line, idles high.
- `tx_end`, out, 1: one-cycle pulse at the end of each frame.

## Operation

- **Reset values:**
  - `rs232_tx` = 1, `tx_busy` = 0, `tx_end` = 0, `tx_ovf` = 0.
  - `tx_empty` = 1, `tx_full` = 0.
  - FIFO pointers and count = 0, baud counter = 0, FSM = IDLE.
- **Reset mid-frame:** the frame is abandoned, the line returns high immediately and FIFO contents are discarded.
- **FIFO:**
  - Pointer-plus-count design. `tx_full` and `tx_empty` come from the registered count.
  - A write when `tx_full` = 1 is dropped and pulses `tx_ovf`, even if a pop occurs in the same cycle.
  - A simultaneous write and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Baud counter:**
  - Counts 0..DIV-1 while the FSM is not in IDLE. The tick is asserted at DIV-1, and the counter then wraps to 0.
  - The counter is cleared on every entry to START, so each bit lasts exactly DIV cycles.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO is not empty, pop the head word into the shift register and go to START.
  - START: line = 0. On tick, go to DATA with bit index 0.
  - DATA: line = shifter[0]. On tick, shift right and increment the index. After `DATA_W` bits, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: line = XOR of the data word (inverted if `PARITY_ODD`). On tick, go to STOP.
  - STOP: line = 1 for `STOP_BITS` ticks. On the final tick, pulse `tx_end`. Then, if FIFO is not empty, pop the next word and go to START directly, with no idle cycle. Otherwise go to IDLE.
- **Parity** is computed when the word is loaded into the shifter, not as bits are shifted out.
- **Line register:** `rs232_tx` is driven from a flop; there is no combinational path to the pin.

## Timing

- **Write to start bit:**
  - A write sampled at edge E0 into an empty FIFO with the FSM in IDLE makes `tx_empty` = 0 after E0.
  - At E1 the word is popped and `rs232_tx` falls. The start bit begins 1 cycle after the write.
- **Frame length:** `(1 + DATA_W + P + STOP_BITS) * DIV` cycles, where P = 1 with parity and 0 without.
- **`tx_end`:** high for exactly the last cycle of the final stop bit.
- **Back-to-back frames:** the next start bit begins on the following cycle.
- **`tx_busy`:** rises with the start bit and falls on the cycle after the last frame's `tx_end`.
- **`tx_ovf`:** valid in the cycle following the rejected write.

## Configuration

- `UART_TX_PARITY_EN` defined:
  - The PARITY state and parity logic are compiled in. One parity bit is sent after the data bits.
  - The parity polarity is set by `PARITY_ODD`.
- Not defined:
  - The PARITY state and parity logic are absent and `PARITY_ODD` is ignored.
  - Frames are `DATA_W`-N-`STOP_BITS`.

## Test plan

All scenarios use `CLK_HZ` = 1000 and `BAUD` = 100, so DIV = 10.

- **8N1 single word:** with no parity, write 0xA5.
  - The line goes low 1 cycle later.
  - Bits 1,0,1,0,0,1,0,1, each 10 cycles.
  - Stop high.
  - `tx_end` pulses at cycle 100 of the frame; `tx_busy` is then low.
- **8E1 parity:** with `UART_TX_PARITY_EN`, write 0xA5 then 0x07.
  - 0xA5 sends parity bit 0; 0x07 sends parity bit 1.
  - Each frame is 110 cycles.
  - With `PARITY_ODD` = 1, both parity bits invert.
- **Back-to-back:** write 3 words on consecutive cycles.
  - The three frames are contiguous, with no idle-high gap between the stop bit and the next start bit.
  - `tx_end` pulses 3 times, 100 cycles apart.
- **Overflow:** with `FIFO_DEPTH` = 4, write 6 words in 6 consecutive cycles.
  - Word 1 pops immediately.
  - Words 2–5 fill the FIFO and `tx_full` = 1.
  - Word 6 is dropped and `tx_ovf` pulses once.
  - Exactly 5 frames are transmitted.
- **7-bit, 2 stop bits:** set `DATA_W` = 7, `STOP_BITS` = 2, no parity, and write 0x55.
  - The frame is 100 cycles.
  - The final 20 cycles are high.
- **Reset mid-frame:** assert `rst` during data bit 3.
  - `rs232_tx` = 1 and `tx_busy` = 0 immediately.
  - `tx_empty` = 1.
  - No `tx_end` pulse.
  - The next write transmits normally.
